// File: rtl/sad_compress_accum.sv
// sad_compress_accum: streaming sum-of-absolute-differences over pixel blocks.
// Three stages: per-lane |a-b| register, carry-save reduction to a sum/carry
// pair, then the block accumulator. A closing beat (in_last or BLK_LEN reached)
// drains the pipeline and holds the result until out_ready.
// Optional feature macro: SAD_SATURATE_EN (clamping accumulator + out_sat port).
module sad_compress_accum #(
  parameter int PIX_W   = 8,
  parameter int LANES   = 8,
  parameter int BLK_LEN = 16,
  parameter int ACC_W   = PIX_W + $clog2(LANES) + $clog2(BLK_LEN) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*PIX_W-1:0]     in_a,
  input  logic [LANES*PIX_W-1:0]     in_b,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_sad,
  output logic [$clog2(BLK_LEN):0]   out_beats,
  output logic                       out_trunc
`ifdef SAD_SATURATE_EN
  ,
  output logic                       out_sat
`endif
);

  localparam int CW = $clog2(BLK_LEN) + 1;
  // Width that holds the exact per-beat lane total.
  localparam int SW = PIX_W + $clog2(LANES) + 1;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PIX_W-1:0]  diff_q [LANES];
  logic [PIX_W-1:0]  diff_d [LANES];
  logic              v1_q, close1_q;
  logic [SW-1:0]     s_q, c_q, s_d, c_d;
  logic              v2_q, close2_q;
  logic              done_q;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CW-1:0]     cnt_q;
  logic              trunc_q;
  logic [SW-1:0]     beat;
  logic              accept, close, release_out;

  assign in_ready    = (state_q == ST_ACC);
  assign accept      = in_valid & in_ready;
  assign close       = accept & (in_last | ((cnt_q + CW'(1)) == CW'(BLK_LEN)));
  assign release_out = (state_q == ST_OUT) & out_ready;

  assign out_valid = (state_q == ST_OUT);
  assign out_sad   = acc_q;
  assign out_beats = cnt_q;
  assign out_trunc = trunc_q;

  // Per-lane absolute difference of the incoming beat.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      logic [PIX_W-1:0] a, b;
      a = in_a[i*PIX_W +: PIX_W];
      b = in_b[i*PIX_W +: PIX_W];
      diff_d[i] = (a > b) ? (a - b) : (b - a);
    end
  end

  // Carry-save reduction of the lane differences (chained 3:2 compressors).
  always_comb begin
    logic [SW-1:0] d, t;
    s_d = '0;
    c_d = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      d   = SW'(diff_q[i]);
      t   = s_d ^ c_d ^ d;
      c_d = ((s_d & c_d) | (s_d & d) | (c_d & d)) << 1;
      s_d = t;
    end
  end

  // Sum+carry is resolved only here, inside the accumulator add.
  assign beat = s_q + c_q;

`ifdef SAD_SATURATE_EN
  localparam int EW = ((ACC_W > SW) ? ACC_W : SW) + 1;
  logic [EW-1:0] ext;
  logic          ovf;
  logic          sat_q;

  // Saturating accumulate: clamp at all-ones on overflow.
  always_comb begin
    ext   = EW'(acc_q) + EW'(beat);
    ovf   = |ext[EW-1:ACC_W];
    acc_d = ovf ? '1 : ext[ACC_W-1:0];
  end

  assign out_sat = sat_q;

  // Sticky overflow flag, cleared when the result is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (release_out) begin
      sat_q <= 1'b0;
    end else if (v2_q && ovf) begin
      sat_q <= 1'b1;
    end
  end
`else
  // Wrapping accumulate, modulo 2^ACC_W.
  always_comb begin
    acc_d = acc_q + ACC_W'(beat);
  end
`endif

  // Stage 1: register lane differences and beat tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      close1_q <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) diff_q[i] <= '0;
    end else begin
      v1_q     <= accept;
      close1_q <= close;
      if (accept) begin
        for (int unsigned i = 0; i < LANES; i++) diff_q[i] <= diff_d[i];
      end
    end
  end

  // Stage 2: register the carry-save pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q     <= 1'b0;
      close2_q <= 1'b0;
      s_q      <= '0;
      c_q      <= '0;
    end else begin
      v2_q     <= v1_q;
      close2_q <= close1_q;
      if (v1_q) begin
        s_q <= s_d;
        c_q <= c_d;
      end
    end
  end

  // Accumulator, beat counter and close-reason flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      done_q <= v2_q & close2_q;
      if (release_out) begin
        acc_q   <= '0;
        cnt_q   <= '0;
        trunc_q <= 1'b0;
      end else begin
        if (v2_q)   acc_q   <= acc_d;
        if (accept) cnt_q   <= cnt_q + CW'(1);
        if (close)  trunc_q <= ~in_last;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ACC;
    else        state_q <= state_d;
  end

  // Next-state: accept -> drain the pipeline -> hold result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC:   if (close)     state_d = ST_DRAIN;
      ST_DRAIN: if (done_q)    state_d = ST_OUT;
      ST_OUT:   if (out_ready) state_d = ST_ACC;
      default:                 state_d = ST_ACC;
    endcase
  end

endmodule

// File: tb/tb_sad_compress_accum.sv
// Directed bench for sad_compress_accum: default instance plus a small
// instance (LANES=2, BLK_LEN=4, ACC_W=8) for wrap / saturation behaviour.
module tb_sad_compress_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default instance.
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [63:0] in_a = '0, in_b = '0;
  logic        out_valid, out_ready = 1'b0, out_trunc;
  logic [15:0] out_sad;
  logic [4:0]  out_beats;

  // Small instance.
  logic        s_in_valid = 1'b0, s_in_ready, s_in_last = 1'b0;
  logic [15:0] s_in_a = '0, s_in_b = '0;
  logic        s_out_valid, s_out_ready = 1'b0, s_out_trunc;
  logic [7:0]  s_out_sad;
  logic [2:0]  s_out_beats;
`ifdef SAD_SATURATE_EN
  logic        out_sat, s_out_sat;
`endif

  int total = 0;
  int bad   = 0;

  sad_compress_accum dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sad(out_sad), .out_beats(out_beats), .out_trunc(out_trunc)
`ifdef SAD_SATURATE_EN
    , .out_sat(out_sat)
`endif
  );

  sad_compress_accum #(.PIX_W(8), .LANES(2), .BLK_LEN(4), .ACC_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b),
    .in_last(s_in_last), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sad(s_out_sad), .out_beats(s_out_beats), .out_trunc(s_out_trunc)
`ifdef SAD_SATURATE_EN
    , .out_sat(s_out_sat)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rep(input logic [7:0] v);
    return {8{v}};
  endfunction

  // Call at a negedge; leaves at the negedge after acceptance.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic last);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_wait", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("pop_valid", {63'd0, out_valid}, 64'd0);
    check("pop_ready", {63'd0, in_ready}, 64'd1);
    check("pop_sad_clr", {48'd0, out_sad}, 64'd0);
  endtask

  initial begin
    logic [63:0] a, b;
    int n;

    // Reset state while rst_n is low.
    #2;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sad", {48'd0, out_sad}, 64'd0);
    check("rst_beats", {59'd0, out_beats}, 64'd0);
    check("rst_trunc", {63'd0, out_trunc}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Small instance: 4 beats of 255 vs 0 on 2 lanes, in_last on the limit beat.
    for (int i = 0; i < 4; i++) begin
      s_in_valid = 1'b1; s_in_a = 16'hFFFF; s_in_b = 16'h0000; s_in_last = (i == 3);
      @(negedge clk);
    end
    s_in_valid = 1'b0; s_in_last = 1'b0;
    check("s_ready_drain", {63'd0, s_in_ready}, 64'd0);
    n = 0;
    while (!s_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("s_out_valid_wait", {63'd0, s_out_valid}, 64'd1);
`ifdef SAD_SATURATE_EN
    check("s_sad_sat", {56'd0, s_out_sad}, 64'd255);
    check("s_sat_flag", {63'd0, s_out_sat}, 64'd1);
`else
    check("s_sad_wrap", {56'd0, s_out_sad}, 64'd248); // 2040 mod 256
`endif
    check("s_beats", {61'd0, s_out_beats}, 64'd4);
    check("s_trunc_last", {63'd0, s_out_trunc}, 64'd0);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    check("s_pop_ready", {63'd0, s_in_ready}, 64'd1);
`ifdef SAD_SATURATE_EN
    check("s_sat_clr", {63'd0, s_out_sat}, 64'd0);
`endif

    // One beat a=200, b=50: latency and value.
    send(rep(8'd200), rep(8'd50), 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("lat_early", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check("lat_exact", {63'd0, out_valid}, 64'd1);
    check("t1_sad", {48'd0, out_sad}, 64'd1200);
    check("t1_beats", {59'd0, out_beats}, 64'd1);
    check("t1_trunc", {63'd0, out_trunc}, 64'd0);
`ifdef SAD_SATURATE_EN
    check("t1_sat", {63'd0, out_sat}, 64'd0);
`endif
    pop();

    // Lane extremes: lane0 0 vs 255, lane7 255 vs 0, others equal.
    a = rep(8'd77); b = rep(8'd77);
    a[7:0] = 8'd0;    b[7:0] = 8'd255;
    a[63:56] = 8'd255; b[63:56] = 8'd0;
    send(a, b, 1'b1);
    wait_out();
    check("ext_sad", {48'd0, out_sad}, 64'd510);
    pop();

    // 16 beats 255 vs 0 without in_last: limit close.
    for (int i = 0; i < 16; i++) begin
      send(rep(8'd255), rep(8'd0), 1'b0);
      if (i == 14) check("lim_ready15", {63'd0, in_ready}, 64'd1);
    end
    check("lim_ready_off", {63'd0, in_ready}, 64'd0);
    wait_out();
    check("lim_sad", {48'd0, out_sad}, 64'd32640);
    check("lim_beats", {59'd0, out_beats}, 64'd16);
    check("lim_trunc", {63'd0, out_trunc}, 64'd1);
    pop();

    // 5 beats a=b+3 with random gaps, then hold out_ready low for 10 cycles.
    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        b[i*8 +: 8] = 8'(10 * i + 7 + k);
        a[i*8 +: 8] = 8'(10 * i + 10 + k);
      end
      send(a, b, k == 4);
    end
    wait_out();
    in_valid = 1'b1; in_a = rep(8'd99); in_b = rep(8'd0);
    for (int i = 0; i < 10; i++) begin
      check("hold_sad", {48'd0, out_sad}, 64'd120);
      check("hold_beats", {59'd0, out_beats}, 64'd5);
      check("hold_ready", {63'd0, in_ready}, 64'd0);
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    pop();

    // Reset asserted during DRAIN of a 4-beat block.
    for (int k = 0; k < 4; k++) send(rep(8'd40), rep(8'd0), k == 3);
    check("drain_ready", {63'd0, in_ready}, 64'd0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    check("arst_ready", {63'd0, in_ready}, 64'd1);
    check("arst_sad", {48'd0, out_sad}, 64'd0);
    check("arst_beats", {59'd0, out_beats}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("arst_no_pulse", 64'(n), 64'd0);
    send(rep(8'd10), rep(8'd20), 1'b1);
    wait_out();
    check("post_rst_sad", {48'd0, out_sad}, 64'd80);
    check("post_rst_beats", {59'd0, out_beats}, 64'd1);
    pop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sad_compress_accum.md
SAD_COMPRESS_ACCUM -- requirements
Module: sad_compress_accum

Interface
REQ-001 Parameter PIX_W, default 8, meaning pixel width in bits, unsigned.
REQ-002 Parameter LANES, default 8, meaning pixel pairs per beat; legal values 2..16.
REQ-003 Parameter BLK_LEN, default 16, meaning maximum beats per block; legal values 1..256.
REQ-004 Derived ACC_W = PIX_W + clog2(LANES) + clog2(BLK_LEN) + 1, meaning result width.
REQ-005 clk  input  1  sole clock, all state rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  beat present.
REQ-008 in_ready  output  1  beat accepted when in_valid and in_ready are both high.
REQ-009 in_a  input  LANES*PIX_W  reference pixels, lane i at bits [i*PIX_W +: PIX_W].
REQ-010 in_b  input  LANES*PIX_W  candidate pixels, same packing.
REQ-011 in_last  input  1  final beat of block.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  result consumed when out_valid and out_ready are both high.
REQ-014 out_sad  output  ACC_W  block SAD.
REQ-015 out_beats  output  clog2(BLK_LEN)+1  beats summed into out_sad.
REQ-016 out_trunc  output  1  block closed by BLK_LEN limit, not by in_last.

Function
REQ-017 Stage 1 SHALL register |a_i - b_i| per lane; a==b SHALL give 0, and 0 vs 2^PIX_W-1 SHALL give 2^PIX_W-1.
REQ-018 Stage 2 SHALL reduce the LANES differences with a 3:2/4:2 compressor tree to a registered sum/carry pair; no carry-propagate adder before the accumulator.
REQ-019 The accumulator SHALL add sum+carry into acc every beat that exits stage 2.
REQ-020 FSM states: ACC (accepting), DRAIN (pipeline flushing), OUT (result held).
REQ-021 ACC->DRAIN on an accepted beat with in_last=1, or on the accepted beat that brings the count to BLK_LEN; for a limit close, out_trunc=1 unless in_last=1 on that beat.
REQ-022 DRAIN->OUT when the closing beat has been accumulated; out_valid SHALL rise exactly 3 cycles after the closing beat is accepted.
REQ-023 OUT->ACC on out_ready; in the same edge acc and count SHALL clear to 0.
REQ-024 in_ready SHALL be 1 only in ACC; no beat is accepted in DRAIN or OUT.
REQ-025 out_sad, out_beats and out_trunc SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 in_valid=0 bubbles in ACC SHALL not alter acc or count; gaps of any length are legal.
REQ-027 Accumulator arithmetic SHALL be modulo 2^ACC_W. The ACC_W margin guarantees no wrap at legal parameters.
REQ-028 With BLK_LEN=1, every accepted beat SHALL close a block; out_trunc SHALL be 0 when in_last=1 and 1 otherwise.

Reset
REQ-029 On rst_n=0, all registers SHALL clear immediately, independent of clk: state=ACC, in_ready=1, out_valid=0, out_sad=0, out_beats=0, out_trunc=0, and pipeline valids=0.
REQ-030 Reset during DRAIN or OUT SHALL discard the partial or pending result; no out_valid pulse follows reset.
REQ-031 Reset release SHALL take effect on the first clk edge after rst_n rises; in_ready SHALL be 1 at that edge.

Configuration
REQ-032 Macro SAD_SATURATE_EN: when defined, the accumulator SHALL clamp at 2^ACC_W-1 and a sticky out_sat flag (output, 1 bit, reset 0, cleared in the OUT->ACC transition) SHALL be added. When undefined, REQ-027 wrap applies and the out_sat port SHALL be absent.

Verification
REQ-033 Defaults; one beat, all a=200, b=50, in_last=1 -> out_sad=1200, out_beats=1, out_trunc=0; out_valid rises 3 cycles after acceptance.
REQ-034 Defaults; 16 beats of a=255, b=0 with no in_last -> out_sad=32640, out_beats=16, out_trunc=1, and in_ready=0 from the cycle after beat 16.
REQ-035 Random in_valid gaps plus out_ready held low for 10 cycles, with 5 beats of a=b+3 -> out_sad=120, output stable while held, and no beat accepted until the handshake completes.
REQ-036 Assert rst_n=0 during DRAIN of a 4-beat block -> all outputs 0 asynchronously; the next block of 1 beat with a=10, b=20 yields out_sad=80.
REQ-037 SAD_SATURATE_EN defined, with ACC_W forced small by a test override -> out_sad=2^ACC_W-1 and out_sat=1; undefined -> the wrapped value matches a modulo model.
